ntt_butterfly_pe: RTL and testbench
===================================

NTT_BUTTERFLY_PE -- requirements
Module: ntt_butterfly_pe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, giving the coefficient, modulus and twiddle width.
REQ-002 SHALL have parameter MUL_STAGES, default 3, giving the pipeline depth of the modular multiplier (range 1..6).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the reset: asynchronous and active-low.
REQ-005 SHALL have port q, input, DATA_W, the modulus: odd, below 2^(DATA_W-1), and stable while busy_o=1.
REQ-006 SHALL have port valid_i, input, 1, which qualifies one input beat.
REQ-007 SHALL have port mode_i, input, 1: 0 selects a Cooley-Tukey (forward) butterfly, 1 a Gentleman-Sande (inverse) butterfly.
REQ-008 SHALL have ports data_top_i, data_bot_i and twiddle_i, each input, DATA_W: the operands.
REQ-009 SHALL have port stall_i, input, 1, which holds the whole pipeline.
REQ-010 SHALL have ports ntt_top_o and ntt_bot_o, each output, DATA_W: the results.
REQ-011 SHALL have port valid_o, output, 1, which qualifies the results.
REQ-012 SHALL have port busy_o, output, 1, asserted while any beat is in flight.
REQ-013 SHALL have port err_o, output, 1, a sticky flag for out-of-range operands.

Function
REQ-014 For mode 0 the block SHALL compute t = bot*w mod q, top_o = (top+t) mod q and bot_o = (top-t) mod q.
REQ-015 For mode 1 the block SHALL compute top_o = (top+bot) mod q and bot_o = ((top-bot) mod q)*w mod q.
REQ-016 Latency SHALL be fixed at LAT = MUL_STAGES+2 unstalled cycles in both modes; mode 1 delays its sum path to match.
REQ-017 mode_i SHALL be captured per beat and travel with it, so modes may alternate every cycle with no bubble.
REQ-018 Full throughput SHALL be one beat per cycle; valid_o SHALL equal valid_i delayed by LAT unstalled cycles.
REQ-019 Modular add and subtract SHALL use a single conditional correction with a DATA_W+1-bit intermediate, giving results in [0, q-1].
REQ-020 The modular multiply SHALL form the exact 2*DATA_W product and reduce it exactly, pipelined within MUL_STAGES registers.
REQ-021 While stall_i=1, every pipeline register including the valid bits SHALL hold; inputs presented that cycle SHALL be ignored.
REQ-022 Outputs SHALL hold their last values while valid_o=0; only valid_o qualifies them.
REQ-023 busy_o SHALL be the OR of all in-flight valid bits.
REQ-024 err_o SHALL set on an accepted beat (valid_i=1, stall_i=0) whose top, bot or twiddle is >= q, and SHALL stay set until reset.
REQ-025 The result of a beat that sets err_o is unspecified, but its valid_o pulse SHALL still occur.
REQ-026 Simultaneous accept and retire SHALL both occur in the same cycle.

Reset
REQ-027 reset_n=0 SHALL asynchronously clear all valid bits, valid_o, busy_o and err_o, and drive ntt_top_o and ntt_bot_o to 0.
REQ-028 Reset mid-operation SHALL discard all in-flight beats; the first beat accepted after reset_n deasserts SHALL exit exactly LAT cycles later.

Configuration
REQ-029 Macro PE_INV_HALVE_EN, when defined, SHALL multiply both mode-1 outputs by 2^-1 mod q, to fold the inverse-NTT scaling: x even -> x/2; x odd -> (x+q)/2.
REQ-030 PE_INV_HALVE_EN SHALL leave latency and mode-0 behaviour unchanged.
REQ-031 Without PE_INV_HALVE_EN, mode-1 outputs SHALL be unscaled as in REQ-015.

Verification
REQ-032 Bench SHALL check: q=7681, top=1147, bot=2963, w=1, mode 0 -> top_o=4110, bot_o=5865, valid_o exactly 5 cycles after accept (defaults).
REQ-033 Bench SHALL check: same operands with w=17, mode 0 -> top_o=5432, bot_o=4543.
REQ-034 Bench SHALL check: same operands with w=1, mode 1 -> 4110/5865 without the macro and 2055/6773 with PE_INV_HALVE_EN.
REQ-035 Bench SHALL check: back-to-back beats alternating mode 0/1 with stall_i pulsed for 3 cycles mid-stream -> every result is correct and in order, and valid_o is held during the stall.
REQ-036 Bench SHALL check: beat with top=7681 (>= q) -> err_o=1 persisting through later good beats until reset_n pulses low.
REQ-037 Bench SHALL check: reset_n asserted with 3 beats in flight -> outputs 0, valid_o and busy_o low immediately, and none of those beats emerges after release.

Source files
------------

// File: rtl/ntt_butterfly_pe.sv
// Pipelined NTT butterfly: Cooley-Tukey (mode 0) or Gentleman-Sande (mode 1), latency MUL_STAGES+2.
// Optional macro PE_INV_HALVE_EN scales both mode-1 outputs by 2^-1 mod q.
module ntt_butterfly_pe #(
  parameter int DATA_W     = 16,
  parameter int MUL_STAGES = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] q,
  input  logic              valid_i,
  input  logic              mode_i,
  input  logic [DATA_W-1:0] data_top_i,
  input  logic [DATA_W-1:0] data_bot_i,
  input  logic [DATA_W-1:0] twiddle_i,
  input  logic              stall_i,
  output logic [DATA_W-1:0] ntt_top_o,
  output logic [DATA_W-1:0] ntt_bot_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int PW = 2 * DATA_W;

  // Handshake: a beat is accepted on a rising edge with valid_i=1 and stall_i=0;
  // valid_o marks a new result and every register (valid bits included) holds while stall_i=1.
  logic adv;
  assign adv = ~stall_i;

  function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] a, b, m);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] a, b, m);
    logic [DATA_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + {1'b0, m};
    return d[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] mod_half(input logic [DATA_W-1:0] x, m);
    logic [DATA_W:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return s[DATA_W:1];
  endfunction

  logic              s0_vld_q, s0_mode_q;
  logic [DATA_W-1:0] s0_top_q, s0_bot_q, s0_tw_q;
  logic [PW-1:0]     mp0_q;
  logic [DATA_W-1:0] ms_q [MUL_STAGES];
  logic              mv_q [MUL_STAGES];
  logic              mm_q [MUL_STAGES];
  logic              out_vld_q, err_q;
  logic [DATA_W-1:0] top_q, bot_q, top_d, bot_d;
  logic [DATA_W-1:0] mul_a, side_d, red, mul_r;
  logic [PW-1:0]     prod;

  // Mode 1 subtracts before the multiplier; its sum rides alongside in ms_q to keep both modes at equal latency.
  always_comb begin
    mul_a  = s0_mode_q ? mod_sub(s0_top_q, s0_bot_q, q) : s0_bot_q;
    side_d = s0_mode_q ? mod_add(s0_top_q, s0_bot_q, q) : s0_top_q;
    prod   = PW'(mul_a) * PW'(s0_tw_q);
  end

  assign red = DATA_W'(mp0_q % PW'(q));

  generate
    if (MUL_STAGES == 1) begin : g_no_dly
      assign mul_r = red;
    end else begin : g_dly
      logic [DATA_W-1:0] mr_q [MUL_STAGES-1];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < MUL_STAGES-1; i++) mr_q[i] <= '0;
        end else if (adv) begin
          mr_q[0] <= red;
          for (int i = 1; i < MUL_STAGES-1; i++) mr_q[i] <= mr_q[i-1];
        end
      end
      assign mul_r = mr_q[MUL_STAGES-2];
    end
  endgenerate

  always_comb begin
    top_d = mod_add(ms_q[MUL_STAGES-1], mul_r, q);
    bot_d = mod_sub(ms_q[MUL_STAGES-1], mul_r, q);
    if (mm_q[MUL_STAGES-1]) begin
`ifdef PE_INV_HALVE_EN
      top_d = mod_half(ms_q[MUL_STAGES-1], q);
      bot_d = mod_half(mul_r, q);
`else
      top_d = ms_q[MUL_STAGES-1];
      bot_d = mul_r;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_vld_q  <= 1'b0;
      s0_mode_q <= 1'b0;
      s0_top_q  <= '0;
      s0_bot_q  <= '0;
      s0_tw_q   <= '0;
      mp0_q     <= '0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        ms_q[i] <= '0;
        mv_q[i] <= 1'b0;
        mm_q[i] <= 1'b0;
      end
      out_vld_q <= 1'b0;
      top_q     <= '0;
      bot_q     <= '0;
      err_q     <= 1'b0;
    end else if (adv) begin
      s0_vld_q  <= valid_i;
      s0_mode_q <= mode_i;
      s0_top_q  <= data_top_i;
      s0_bot_q  <= data_bot_i;
      s0_tw_q   <= twiddle_i;
      mp0_q     <= prod;
      ms_q[0]   <= side_d;
      mv_q[0]   <= s0_vld_q;
      mm_q[0]   <= s0_mode_q;
      for (int i = 1; i < MUL_STAGES; i++) begin
        ms_q[i] <= ms_q[i-1];
        mv_q[i] <= mv_q[i-1];
        mm_q[i] <= mm_q[i-1];
      end
      out_vld_q <= mv_q[MUL_STAGES-1];
      if (mv_q[MUL_STAGES-1]) begin
        top_q <= top_d;
        bot_q <= bot_d;
      end
      if (valid_i && (data_top_i >= q || data_bot_i >= q || twiddle_i >= q)) err_q <= 1'b1;
    end
  end

  logic busy_any;
  always_comb begin
    busy_any = s0_vld_q | out_vld_q;
    for (int i = 0; i < MUL_STAGES; i++) busy_any = busy_any | mv_q[i];
  end

  assign ntt_top_o = top_q;
  assign ntt_bot_o = bot_q;
  assign valid_o   = out_vld_q;
  assign busy_o    = busy_any;
  assign err_o     = err_q;

endmodule

// File: tb/tb_ntt_butterfly_pe.sv
// Directed bench for ntt_butterfly_pe with a reference model and an in-order scoreboard.
module tb_ntt_butterfly_pe;

  localparam int W   = 16;
  localparam int LAT = 5;
  localparam int QV  = 7681;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] q_mod;
  logic         valid_i, mode_i, stall_i;
  logic [W-1:0] data_top_i, data_bot_i, twiddle_i;
  logic [W-1:0] ntt_top_o, ntt_bot_o;
  logic         valid_o, busy_o, err_o;

  ntt_butterfly_pe dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .q          (q_mod),
    .valid_i    (valid_i),
    .mode_i     (mode_i),
    .data_top_i (data_top_i),
    .data_bot_i (data_bot_i),
    .twiddle_i  (twiddle_i),
    .stall_i    (stall_i),
    .ntt_top_o  (ntt_top_o),
    .ntt_bot_o  (ntt_bot_o),
    .valid_o    (valid_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int ucnt   = 0;
  bit last_adv = 1'b0;

  logic [31:0] exp_q[$];
  int          stamp_q[$];
  bit          dc_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int half_mod(input int x, input int qq);
    return (x % 2 == 0) ? x / 2 : (x + qq) / 2;
  endfunction

  function automatic logic [31:0] model(input int top, input int bot, input int w, input bit m, input int qq);
    int t, a, b;
    if (!m) begin
      t = (bot * w) % qq;
      a = (top + t) % qq;
      b = (top - t + qq) % qq;
    end else begin
      a = (top + bot) % qq;
      b = (((top - bot + qq) % qq) * w) % qq;
`ifdef PE_INV_HALVE_EN
      a = half_mod(a, qq);
      b = half_mod(b, qq);
`endif
    end
    return {a[15:0], b[15:0]};
  endfunction

  // Expected results are pushed on the accepting edge, stamped with the unstalled-edge count.
  always @(posedge clk) begin
    last_adv = 1'b0;
    if (reset_n && !stall_i) begin
      if (valid_i) begin
        exp_q.push_back(model(int'(data_top_i), int'(data_bot_i), int'(twiddle_i), mode_i, int'(q_mod)));
        stamp_q.push_back(ucnt);
        dc_q.push_back(data_top_i >= q_mod || data_bot_i >= q_mod || twiddle_i >= q_mod);
      end
      ucnt++;
      last_adv = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    int          s;
    bit          dc;
    if (reset_n && last_adv && valid_o) begin
      check("out_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        s  = stamp_q.pop_front();
        dc = dc_q.pop_front();
        check("latency", ucnt - s, LAT);
        if (!dc) begin
          check("top_o", ntt_top_o, e[31:16]);
          check("bot_o", ntt_bot_o, e[15:0]);
        end
      end
    end
  end

  task automatic set_beat(input bit m, input int t, input int b, input int w);
    valid_i    = 1'b1;
    mode_i     = m;
    data_top_i = W'(t);
    data_bot_i = W'(b);
    twiddle_i  = W'(w);
  endtask

  task automatic drive(input bit m, input int t, input int b, input int w);
    @(negedge clk);
    set_beat(m, t, b, w);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle(1);
    check("drain_empty", exp_q.size(), 0);
    idle(1);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    stamp_q.delete();
    dc_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] snap_top, snap_bot;
    reset_n = 1'b0; q_mod = W'(QV); valid_i = 1'b0; mode_i = 1'b0; stall_i = 1'b0;
    data_top_i = '0; data_bot_i = '0; twiddle_i = '0;
    #3;
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_top", ntt_top_o, 0);
    check("rst_bot", ntt_bot_o, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    drive(0, 1147, 2963, 1); idle(1); drain();
    check("ct_w1_top", ntt_top_o, 4110);
    check("ct_w1_bot", ntt_bot_o, 5865);

    drive(0, 1147, 2963, 17); idle(1); drain();
    check("ct_w17_top", ntt_top_o, 5432);
    check("ct_w17_bot", ntt_bot_o, 4543);

    drive(1, 1147, 2963, 1); idle(1); drain();
`ifdef PE_INV_HALVE_EN
    check("gs_w1_top", ntt_top_o, 2055);
    check("gs_w1_bot", ntt_bot_o, 6773);
`else
    check("gs_w1_top", ntt_top_o, 4110);
    check("gs_w1_bot", ntt_bot_o, 5865);
`endif

    // Alternating modes back to back, with a 3-cycle stall in the middle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 5) begin
        stall_i = 1'b1;
        set_beat(1, $urandom_range(0, QV-1), $urandom_range(0, QV-1), $urandom_range(0, QV-1));
        snap_top = ntt_top_o;
        snap_bot = ntt_bot_o;
        check("stall_pre_valid", valid_o, 1);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_hold_valid", valid_o, 1);
          check("stall_hold_top", ntt_top_o, snap_top);
          check("stall_hold_bot", ntt_bot_o, snap_bot);
        end
        stall_i = 1'b0;
      end
      set_beat(i[0], $urandom_range(0, QV-1), $urandom_range(0, QV-1), $urandom_range(0, QV-1));
    end
    idle(1); drain();

    drive(0, QV, 2963, 17); idle(1);
    check("err_set", err_o, 1);
    drive(1, 100, 200, 3);
    drive(0, 5000, 7000, 4000); idle(1); drain();
    check("err_sticky", err_o, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("err_cleared", err_o, 0);
    clear_sb();
    @(negedge clk);
    reset_n = 1'b1;

    drive(0, 1147, 2963, 1); idle(1); drain();
    drive(0, 11, 22, 33);
    drive(1, 44, 55, 66);
    drive(0, 77, 88, 99);
    @(posedge clk);
    #2;
    valid_i = 1'b0;
    check("busy_inflight", busy_o, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_top", ntt_top_o, 0);
    check("mid_rst_bot", ntt_bot_o, 0);
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_busy", busy_o, 0);
    clear_sb();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(LAT + 5);
    check("no_ghost_busy", busy_o, 0);

    drive(0, 1147, 2963, 17); idle(1); drain();
    check("post_rst_top", ntt_top_o, 5432);
    check("post_rst_bot", ntt_bot_o, 4543);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
